// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment (SSD) blocks: character codes,
// active-low glyph patterns (bit 6 = g ... bit 0 = a), frame reset value
// and the scan decoder state type.
package ssd_pkg;

  // 5-bit character codes beyond the hex range
  localparam logic [4:0] SSD_BLANK = 5'h10;
  localparam logic [4:0] SSD_U     = 5'h11;
  localparam logic [4:0] SSD_UNK   = 5'h1F;

  // Active-low glyph patterns, ordered g,f,e,d,c,b,a
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_U     = 7'b1000001;

  // Idle anode bus (no digit selected)
  localparam logic [3:0] SSD_AN_IDLE = 4'b1111;

  // Four blank characters packed digit3..digit0
  localparam logic [19:0] SSD_FRAME_RST = 20'h84210;

  // Per-slot settle filter state
  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } ssd_state_e;

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Scan bus plus decoded results of the SSD scan decoder.
// master: the side driving the display bus and watching the results.
// slave : the decoder itself.
interface ssd_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [19:0] frame_code;
  logic        frame_valid;
  logic        scan_lost;
  logic [7:0]  err_cnt;

  modport master (
    output an, seg,
    input  frame_code, frame_valid, scan_lost, err_cnt
  );

  modport slave (
    input  an, seg,
    output frame_code, frame_valid, scan_lost, err_cnt
  );
endinterface

// File: rtl/ssd_glyph_decode.sv
// Combinational active-low seven-segment glyph to 5-bit character code.
// Hex glyphs map to 0x00-0x0F, blank to 0x10, 'U' to 0x11, all else 0x1F.
// 'O' shares the '0' pattern and therefore decodes to 0x00.
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [4:0] code_o
);

  // Pattern lookup
  always_comb begin
    code_o = SSD_UNK;
    case (seg_i)
      GLYPH_0:     code_o = 5'h00;
      GLYPH_1:     code_o = 5'h01;
      GLYPH_2:     code_o = 5'h02;
      GLYPH_3:     code_o = 5'h03;
      GLYPH_4:     code_o = 5'h04;
      GLYPH_5:     code_o = 5'h05;
      GLYPH_6:     code_o = 5'h06;
      GLYPH_7:     code_o = 5'h07;
      GLYPH_8:     code_o = 5'h08;
      GLYPH_9:     code_o = 5'h09;
      GLYPH_A:     code_o = 5'h0A;
      GLYPH_B:     code_o = 5'h0B;
      GLYPH_C:     code_o = 5'h0C;
      GLYPH_D:     code_o = 5'h0D;
      GLYPH_E:     code_o = 5'h0E;
      GLYPH_F:     code_o = 5'h0F;
      GLYPH_BLANK: code_o = SSD_BLANK;
      GLYPH_U:     code_o = SSD_U;
      default:     code_o = SSD_UNK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Recovers the four displayed characters from a multiplexed active-low
// seven-segment scan bus. Each anode slot must be stable for SETTLE samples
// before its glyph is captured; a frame is published once every digit in
// DIGIT_MASK has been captured.
// Optional build macro SSD_DEC_SYNC_EN: inserts a 2-flop synchronizer on
// an/seg for pin-level capture (adds 2 cycles of latency).
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int         SETTLE     = 4,
  parameter int         TIMEOUT    = 524288,
  parameter logic [3:0] DIGIT_MASK = 4'b1111
) (
  input  logic           clk,
  input  logic           reset,
  ssd_scan_decoder_if.slave bus
);

  localparam int         IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TO_C  = IW'(TIMEOUT);
  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  logic [3:0] an_s;
  logic [6:0] seg_s;

`ifdef SSD_DEC_SYNC_EN
  logic [3:0] an_m_q, an_s_q;
  logic [6:0] seg_m_q, seg_s_q;

  // Two-stage synchronizer; resets to the idle bus
  always_ff @(posedge clk) begin
    if (reset) begin
      an_m_q  <= SSD_AN_IDLE;
      an_s_q  <= SSD_AN_IDLE;
      seg_m_q <= GLYPH_BLANK;
      seg_s_q <= GLYPH_BLANK;
    end else begin
      an_m_q  <= bus.an;
      an_s_q  <= an_m_q;
      seg_m_q <= bus.seg;
      seg_s_q <= seg_m_q;
    end
  end

  assign an_s  = an_s_q;
  assign seg_s = seg_s_q;
`else
  assign an_s  = bus.an;
  assign seg_s = bus.seg;
`endif

  // Sample classification
  logic [2:0]  low_cnt;
  logic        valid_slot;
  logic        multi_an;
  logic [10:0] sample;
  logic        changed;
  logic [4:0]  glyph_code;

  logic [10:0]      prev_q;
  ssd_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             capture;
  logic [IW-1:0]    idle_q, idle_d;
  logic             timeout_hit;
  logic [3:0]       seen_q, seen_d;
  logic             frame_done;
  logic             multi_q;
  logic [7:0]       err_q;
  logic             lost_q;
  logic             frame_valid_q;
  logic [19:0]      frame_code_q;
  logic [19:0]      work_flat;

  assign low_cnt    = 3'($countones(~an_s));
  assign valid_slot = (low_cnt == 3'd1);
  assign multi_an   = (low_cnt >= 3'd2);
  assign sample     = {an_s, seg_s};
  assign changed    = (sample != prev_q);

  ssd_glyph_decode u_glyph (
    .seg_i  (seg_s),
    .code_o (glyph_code)
  );

  // Settle filter: any change restarts the stable count, invalid drops to WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!valid_slot) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else if (state_q == ST_WAIT || changed) begin
      cnt_d = 8'd1;
      if (SETTLE_C == 8'd1) begin
        capture = 1'b1;
        state_d = ST_HELD;
      end else begin
        state_d = ST_SETTLE;
      end
    end else if (state_q == ST_SETTLE) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == SETTLE_C) begin
        capture = 1'b1;
        state_d = ST_HELD;
      end
    end
  end

  // Saturating count of cycles without a valid slot; fires once on reaching TIMEOUT
  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if (valid_slot) begin
      idle_d = '0;
    end else if (idle_q != TO_C) begin
      idle_d = idle_q + IW'(1);
      if (idle_d == TO_C) timeout_hit = 1'b1;
    end
  end

  // Seen mask: publishing clears it, a same-cycle capture opens the next frame
  always_comb begin
    frame_done = ((seen_q & DIGIT_MASK) == DIGIT_MASK);
    seen_d     = frame_done ? 4'b0000 : seen_q;
    if (capture) seen_d = seen_d | ~an_s;
    if (timeout_hit) seen_d = 4'b0000;
  end

  // Control state, counters and published outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q        <= {SSD_AN_IDLE, GLYPH_BLANK};
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      idle_q        <= '0;
      seen_q        <= '0;
      multi_q       <= 1'b0;
      err_q         <= '0;
      lost_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_code_q  <= SSD_FRAME_RST;
    end else begin
      prev_q        <= sample;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      seen_q        <= seen_d;
      multi_q       <= multi_an;
      frame_valid_q <= frame_done;
      if (frame_done) frame_code_q <= work_flat;
      if (multi_an && !multi_q && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (timeout_hit) lost_q <= 1'b1;
      else if (capture) lost_q <= 1'b0;
    end
  end

  // Per-digit working registers, blanked on reset and on scan loss
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [4:0] work_q;

      // Capture the decoded glyph when this digit's anode is the active slot
      always_ff @(posedge clk) begin
        if (reset || timeout_hit) begin
          work_q <= SSD_BLANK;
        end else if (capture && !an_s[gi]) begin
          work_q <= glyph_code;
        end
      end

      assign work_flat[gi*5 +: 5] = work_q;
    end
  endgenerate

  assign bus.frame_code  = frame_code_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.scan_lost   = lost_q;
  assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Self-checking bench for ssd_scan_decoder: table-driven glyph frames,
// hand-written timing/corner sequences and a randomized scan checked
// every cycle against a behavioural model.
module tb_ssd_scan_decoder;

  localparam int         SETTLE  = 4;
  localparam int         TIMEOUT = 64;
  localparam logic [3:0] MASK    = 4'b1111;
`ifdef SSD_DEC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_decoder_if bus ();

  ssd_scan_decoder #(
    .SETTLE     (SETTLE),
    .TIMEOUT    (TIMEOUT),
    .DIGIT_MASK (MASK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_count = 0;
  int fv_cyc   = -1;
  logic [19:0] fv_code = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  hex_glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [10:0] dq [$];
  logic [10:0] m_last;
  int          m_run;
  logic [3:0]  m_seen;
  logic [4:0]  m_work [4];
  logic [19:0] m_code;
  logic        m_fv, m_lost, m_multi_prev;
  int          m_err, m_idle;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (s == hex_glyph[i]) return 5'(i);
    if (s == 7'b1111111) return 5'h10;
    if (s == 7'b1000001) return 5'h11;
    return 5'h1F;
  endfunction

  task automatic model_reset();
    dq.delete();
    for (int i = 0; i < LAT; i++) dq.push_back(11'h7FF);
    m_last = 11'h7FF;
    m_run  = 0;
    m_seen = 4'b0000;
    for (int i = 0; i < 4; i++) m_work[i] = 5'h10;
    m_code = 20'h84210;
    m_fv = 1'b0; m_lost = 1'b0; m_multi_prev = 1'b0;
    m_err = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic [3:0] an, input logic [6:0] seg);
    logic [10:0] s;
    int zeros, dig;
    logic valid, multi, pend;
    dq.push_back({an, seg});
    s = dq.pop_front();
    zeros = 0; dig = 0;
    for (int i = 0; i < 4; i++) if (!s[7+i]) begin zeros++; dig = i; end
    valid = (zeros == 1);
    multi = (zeros >= 2);
    pend  = ((m_seen & MASK) == MASK);
    m_fv  = pend;
    if (pend) begin
      m_code = {m_work[3], m_work[2], m_work[1], m_work[0]};
      m_seen = 4'b0000;
    end
    m_run  = (s == m_last) ? m_run + 1 : 1;
    m_last = s;
    if (valid && m_run == SETTLE) begin
      m_work[dig] = ref_decode(s[6:0]);
      m_seen[dig] = 1'b1;
      m_lost = 1'b0;
    end
    if (multi && !m_multi_prev && m_err < 255) m_err++;
    m_multi_prev = multi;
    if (valid) m_idle = 0;
    else if (m_idle < TIMEOUT) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_lost = 1'b1;
        m_seen = 4'b0000;
        for (int i = 0; i < 4; i++) m_work[i] = 5'h10;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [3:0] an, input logic [6:0] seg);
    bus.an  = an;
    bus.seg = seg;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(an, seg);
    #1;
    cyc++;
    check("frame_code",  32'(bus.frame_code),  32'(m_code));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    check("scan_lost",   32'(bus.scan_lost),   32'(m_lost));
    check("err_cnt",     32'(bus.err_cnt),     32'(m_err));
    if (bus.frame_valid) begin
      fv_count++;
      fv_cyc  = cyc;
      fv_code = bus.frame_code;
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) step(an, seg);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold(4'b1111, 7'h7F, 2);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] a;
    a = 4'b1111;
    a[d] = 1'b0;
    return a;
  endfunction

  typedef struct {
    logic [6:0] seg;
    logic [4:0] code;
  } glyph_vec_t;

  glyph_vec_t vecs [20];

  initial begin
    logic [19:0] exp_code;
    int lost_cyc;

    vecs[0]  = '{7'b1000000, 5'h00}; vecs[1]  = '{7'b1111001, 5'h01};
    vecs[2]  = '{7'b0100100, 5'h02}; vecs[3]  = '{7'b0110000, 5'h03};
    vecs[4]  = '{7'b0011001, 5'h04}; vecs[5]  = '{7'b0010010, 5'h05};
    vecs[6]  = '{7'b0000010, 5'h06}; vecs[7]  = '{7'b1111000, 5'h07};
    vecs[8]  = '{7'b0000000, 5'h08}; vecs[9]  = '{7'b0010000, 5'h09};
    vecs[10] = '{7'b0001000, 5'h0A}; vecs[11] = '{7'b0000011, 5'h0B};
    vecs[12] = '{7'b1000110, 5'h0C}; vecs[13] = '{7'b0100001, 5'h0D};
    vecs[14] = '{7'b0000110, 5'h0E}; vecs[15] = '{7'b0001110, 5'h0F};
    vecs[16] = '{7'b1111111, 5'h10}; vecs[17] = '{7'b1000001, 5'h11};
    vecs[18] = '{7'b0101010, 5'h1F}; vecs[19] = '{7'b1110111, 5'h1F};

    bus.an  = 4'b1111;
    bus.seg = 7'h7F;

    // Reset values
    do_reset();
    check("rst_frame_code",  32'(bus.frame_code),  32'h84210);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
    check("rst_scan_lost",   32'(bus.scan_lost),   32'h0);
    check("rst_err_cnt",     32'(bus.err_cnt),     32'h0);
    $display("txn reset: frame_code=%h", bus.frame_code);

    // Single frame capture and its timing
    cyc = 0; fv_count = 0; fv_cyc = -1;
    hold(4'b1110, 7'b1000001, 10);
    hold(4'b1101, 7'b1111111, 10);
    hold(4'b1011, 7'b1111111, 10);
    hold(4'b0111, 7'b1111111, 10);
    check("single_fv_count", 32'(fv_count), 32'd1);
    check("single_fv_cycle", 32'(fv_cyc), 32'(30 + LAT + SETTLE + 1));
    check("single_code", 32'(fv_code), 32'h84211);
    $display("txn single frame: pulse cycle %0d code %h", fv_cyc, fv_code);

    // Glitch of SETTLE-1 cycles is rejected
    fv_count = 0;
    hold(4'b1110, 7'b1111001, 2);
    hold(4'b1110, 7'b0000000, 3);
    hold(4'b1110, 7'b1111001, 10);
    for (int d = 1; d < 4; d++) hold(an_of(d), 7'h7F, 10);
    hold(4'b1111, 7'h7F, 2);
    check("glitch_fv_count", 32'(fv_count), 32'd1);
    check("glitch_digit0", 32'(fv_code[4:0]), 32'h01);
    $display("txn glitch: digit0 code %h", fv_code[4:0]);

    // Glyph table, four glyphs per frame
    for (int g = 0; g < 5; g++) begin
      fv_count = 0;
      for (int d = 0; d < 4; d++) hold(an_of(d), vecs[g*4+d].seg, 6);
      hold(4'b1111, 7'h7F, 3);
      exp_code = {vecs[g*4+3].code, vecs[g*4+2].code, vecs[g*4+1].code, vecs[g*4].code};
      check("table_fv_count", 32'(fv_count), 32'd1);
      check("table_code", 32'(fv_code), 32'(exp_code));
      $display("txn table group %0d: code %h", g, fv_code);
    end

    // Randomized scan against the model
    for (int t = 0; t < 200; t++) begin
      int kind, hl;
      logic [3:0] an;
      logic [6:0] seg;
      kind = int'($urandom_range(0, 9));
      hl   = int'($urandom_range(1, 7));
      if (kind == 0) an = 4'b1111;
      else if (kind == 1) begin
        int i, j;
        i = int'($urandom_range(0, 3));
        j = (i + int'($urandom_range(1, 3))) % 4;
        an = an_of(i) & an_of(j);
      end else an = an_of(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
      else seg = vecs[$urandom_range(0, 19)].seg;
      hold(an, seg, hl);
      $display("txn rand %0d: an=%b seg=%b hold=%0d", t, an, seg, hl);
    end

    // Multi-anode counting and saturation
    do_reset();
    fv_count = 0;
    for (int k = 0; k < 3; k++) begin
      hold(4'b0101, 7'h7F, 10);
      hold(4'b1111, 7'h7F, 5);
    end
    check("multi_err3", 32'(bus.err_cnt), 32'd3);
    check("multi_no_capture", 32'(fv_count), 32'd0);
    for (int k = 0; k < 300; k++) begin
      step(4'b0011, 7'h7F);
      step(4'b1111, 7'h7F);
    end
    check("multi_err_sat", 32'(bus.err_cnt), 32'd255);
    $display("txn multi-anode: err_cnt %0d", bus.err_cnt);

    // Timeout, seen clearing and recovery
    do_reset();
    hold(4'b1110, 7'b0010010, 10);
    cyc = 0; lost_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      step(4'b1111, 7'h7F);
      if (bus.scan_lost) begin
        lost_cyc = cyc;
        break;
      end
    end
    check("timeout_cycle", 32'(lost_cyc), 32'(LAT + TIMEOUT));
    fv_count = 0;
    hold(4'b1101, 7'b0000010, 10);
    check("lost_cleared", 32'(bus.scan_lost), 32'd0);
    hold(4'b1011, 7'b1111000, 10);
    hold(4'b0111, 7'b0000000, 10);
    check("timeout_seen_cleared", 32'(fv_count), 32'd0);
    hold(4'b1110, 7'b1111001, 10);
    hold(4'b1111, 7'h7F, 2);
    check("recover_fv_count", 32'(fv_count), 32'd1);
    check("recover_code", 32'(fv_code), 32'({5'h08, 5'h07, 5'h06, 5'h01}));
    $display("txn timeout: lost at cycle %0d, recovered code %h", lost_cyc, fv_code);

    // Reset in the middle of a frame
    hold(4'b1110, 7'b0010010, 10);
    hold(4'b1101, 7'b0000010, 10);
    do_reset();
    fv_count = 0;
    hold(4'b1011, 7'b1111000, 10);
    hold(4'b0111, 7'b0000000, 10);
    check("midrst_no_fv", 32'(fv_count), 32'd0);
    check("midrst_code_held", 32'(bus.frame_code), 32'h84210);
    hold(4'b1110, 7'b1111001, 10);
    hold(4'b1101, 7'b0100100, 10);
    hold(4'b1111, 7'h7F, 3);
    check("midrst_fv_count", 32'(fv_count), 32'd1);
    check("midrst_code", 32'(fv_code), 32'({5'h08, 5'h07, 5'h02, 5'h01}));
    $display("txn reset mid-frame: code %h", fv_code);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Recovers the four displayed characters from a multiplexed, active-low seven-segment scan bus (`an`/`seg`). It is the receiving end of the SSD display drivers. Used as a loopback monitor in benches and as an on-chip self-check of what the display is showing. Each anode slot is qualified by a settle filter and its glyph is decoded to a 5-bit character code. A complete frame is published once every enabled digit has been captured.

## Interface
- `SETTLE`, default 4: number of consecutive identical samples required before a digit is captured (range 1–255).
- `TIMEOUT`, default 524288: number of consecutive cycles with no valid anode before `scan_lost` asserts.
- `DIGIT_MASK`, default 4'b1111: digits that must be captured to complete a frame.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `an`, input, 4: anode bus, active-low. Bit 0 is the rightmost digit.
- `seg`, input, 7: cathode bus, active-low. Bit order is g,f,e,d,c,b,a (bit 6 = g).
- `frame_code`, output, 20: decoded frame. Digit3 is in [19:15] and digit0 is in [4:0].
- `frame_valid`, output, 1: one-cycle pulse when `frame_code` updates.
- `scan_lost`, output, 1: level. High while the anode timeout has expired.
- `err_cnt`, output, 8: saturating count of multi-anode events.

## Operation
- **Sample.** Sampled `an`/`seg` are "valid-slot" only when exactly one `an` bit is 0. `an`=1111 is idle. Two or more low bits is a multi-anode error.
- **FSM states.**
  - WAIT: no valid slot. Enter SETTLE when a valid slot is sampled; the stable counter loads 1.
  - SETTLE: each sample with the same `{an,seg}` as the previous sample increments the stable counter. Any change returns the FSM to SETTLE with the counter reloaded to 1, or to WAIT if the new sample is not a valid slot. When the counter reaches `SETTLE`, the digit is captured and the FSM moves to HELD.
  - HELD: stays here while `{an,seg}` is unchanged, with no re-capture. Any change is handled exactly as a change in SETTLE.
- **Capture.** Write the decoded code into the working register for the active digit and set that digit's bit in the `seen` mask.
- **Frame completion.** When `(seen & DIGIT_MASK) == DIGIT_MASK` after a capture:
  - copy the working registers to `frame_code` on the next edge;
  - pulse `frame_valid` in that same cycle;
  - clear `seen`.
  - A capture on the completion cycle itself starts the next frame.
- **Glyph decode** (7-bit active-low pattern to 5-bit code):
  - Hex digits 0–F, in order: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110 decode to 0x00–0x0F.
  - 1111111 (blank) decodes to 0x10.
  - 1000001 ('U') decodes to 0x11.
  - Any other pattern decodes to 0x1F.
  - 'O' is identical to '0' and decodes to 0x00.
- **Multi-anode error.**
  - `err_cnt` increments on entry into the multi-anode condition (rising edge of the condition, not every cycle) and saturates at 255.
  - No capture occurs and the FSM goes to WAIT.
- **Timeout.**
  - The idle/invalid counter counts cycles without a valid slot. When it reaches `TIMEOUT`: `scan_lost` sets, `seen` clears, and the working registers reset to blank.
  - `scan_lost` clears on the next capture.
  - The counter resets on any valid-slot sample and saturates.
- **Reset** (at any point, including mid-frame):
  - FSM goes to WAIT; `seen` is cleared; all counters are cleared.
  - Working registers and `frame_code` reset to 0x84210 (all blank).
  - `frame_valid`, `scan_lost` and `err_cnt` reset to 0.

## Timing
- With `SSD_DEC_SYNC_EN`, there are 2 cycles of input synchronizer latency (L=2); without it, L=0.
- If `{an,seg}` is applied at cycle 0 and held, the capture occurs at the edge of cycle L+SETTLE.
- `frame_valid` is asserted in the cycle after the completing capture, with `frame_code` valid in that same cycle.
- `scan_lost` rises L+TIMEOUT cycles after the last valid-slot input.
- The maximum input glitch rejected is SETTLE−1 cycles.

## Configuration
- `SSD_DEC_SYNC_EN` defined: `an` and `seg` pass through a 2-flop synchronizer before all logic. Use this for pin-level capture.
- `SSD_DEC_SYNC_EN` undefined: the inputs are used directly. Use this for same-clock on-chip loopback. All behaviour other than the L latency is identical.

## Structure
- Shared package `ssd_pkg`:
  - character-code constants (`SSD_BLANK`=0x10, `SSD_U`=0x11, `SSD_UNK`=0x1F);
  - the glyph pattern constants;
  - the frame reset constant 0x84210;
  - the FSM state enum (WAIT/SETTLE/HELD).
- Sub-module `ssd_glyph_decode`: purely combinational, 7-bit pattern in, 5-bit code out. It is shared with future SSD blocks.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles → `frame_code`=0x84210, `frame_valid`=0, `scan_lost`=0, `err_cnt`=0.
- **Single frame capture.** With sync enabled and SETTLE=4, scan `an`=1110/`seg`=1000001, then 1101, 1011 and 0111 with `seg`=1111111, each held 10 cycles → exactly one `frame_valid` pulse, asserted at cycle 37 (the completing capture at cycle 36 plus 1), with `frame_code`=0x84211.
- **Glitch rejection.** Hold `an`=1110 with `seg`=1111001, glitching `seg` to 0000000 for 3 cycles mid-hold → the captured digit0 code is 0x01, never 0x08.
- **Multi-anode error.** Drive `an`=0101 for 10 cycles, three separate times → `err_cnt`=3 with no capture. Repeat 300 entries → `err_cnt` holds at 255.
- **Timeout.** With TIMEOUT=64, drive `an`=1111 → `scan_lost` rises at cycle 66 and `seen` is cleared. A subsequent valid capture clears `scan_lost`.
- **Reset mid-frame.** Assert `reset` after 2 of 4 digits are captured → no `frame_valid` until 4 fresh captures complete, and `frame_code` stays at 0x84210 until then.
